// File: rtl/float_addsub_seq.sv
// Sequential IEEE-754-style adder/subtractor: one pipeline step per FSM state,
// fixed five-cycle latency, flush-to-zero on input and output, round-to-nearest-even.
module float_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 op,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 busy,
  output logic                 done,
  output logic                 flag_ovf,
  output logic                 flag_nan
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int FW  = MAN_W + 1;   // mantissa with implicit one
  localparam int XW  = MAN_W + 4;   // plus guard, round, sticky
  localparam int EW  = EXP_W + 2;   // headroom for carry and round increments
  localparam int LZW = $clog2(XW + 1);
  localparam logic [EXP_W-1:0] EMAX   = '1;
  localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(MAN_W + 3);

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]  a_q, b_q;
  logic          op_q;
  logic [EW-1:0] ex_q, ex_d;
  logic [XW-1:0] mb_q, mb_d, ms_q, ms_d;
  logic          sub_q, sub_d, sgn_q, sgn_d, zs_q, zs_d;
  logic          sp_nan_q, sp_nan_d, sp_inf_q, sp_inf_d, sp_sgn_q, sp_sgn_d;
  logic [XW:0]   sum_q, sum_d;
  logic [XW-1:0] nm_q, nm_d;
  logic [EW-1:0] ne_q, ne_d;
  logic          nz_q, nz_d, nzs_q, nzs_d;
  logic [W-1:0]  result_q, res_d;
  logic          ovf_q, ovf_d, nan_q, nan_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Unpack, classify specials, order by magnitude and align the smaller operand
  logic [EXP_W-1:0] ea, eb, be, se, sh;
  logic [MAN_W-1:0] fa, fb;
  logic [FW-1:0]    ma, mb, bm, sm;
  logic             sa, sb, bs, ss, a_nan, b_nan, a_inf, b_inf;
  logic [XW-1:0]    ext, al;

  always_comb begin
    ea = a_q[W-2:MAN_W];
    eb = b_q[W-2:MAN_W];
    fa = a_q[MAN_W-1:0];
    fb = b_q[MAN_W-1:0];
    sa = a_q[W-1];
    sb = b_q[W-1] ^ op_q;
    ma = (ea == '0) ? '0 : {1'b1, fa};
    mb = (eb == '0) ? '0 : {1'b1, fb};
    a_nan = (ea == EMAX) && (fa != '0);
    b_nan = (eb == EMAX) && (fb != '0);
    a_inf = (ea == EMAX) && (fa == '0);
    b_inf = (eb == EMAX) && (fb == '0);
    be = ea; bm = ma; bs = sa;
    se = eb; sm = mb; ss = sb;
    if ({ea, ma} < {eb, mb}) begin
      be = eb; bm = mb; bs = sb;
      se = ea; sm = ma; ss = sa;
    end
    sh  = be - se;
    ext = {sm, 3'b000};
    if (sh >= SH_MAX) al = {{(XW-1){1'b0}}, |sm};
    else al = (ext >> sh) | {{(XW-1){1'b0}}, |(ext & ~({XW{1'b1}} << sh))};
    ex_d     = {2'b00, be};
    mb_d     = {bm, 3'b000};
    ms_d     = al;
    sub_d    = bs ^ ss;
    sgn_d    = bs;
    zs_d     = sa & sb;
    sp_nan_d = a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
    sp_inf_d = a_inf | b_inf;
    sp_sgn_d = a_inf ? sa : sb;
  end

  always_comb begin
    sum_d = sub_q ? ({1'b0, mb_q} - {1'b0, ms_q}) : ({1'b0, mb_q} + {1'b0, ms_q});
  end

  logic [LZW-1:0] lz;

  always_comb begin
    lz = '0;
    for (int i = 0; i < XW; i++) begin
      if (sum_q[i]) lz = LZW'(XW - 1 - i);
    end
    nm_d  = '0;
    ne_d  = ex_q;
    nz_d  = 1'b0;
    nzs_d = sgn_q;
    if (sum_q == '0) begin
      nz_d  = 1'b1;
      nzs_d = zs_q;
    end else if (sum_q[XW]) begin
      nm_d = {sum_q[XW:2], sum_q[1] | sum_q[0]};
      ne_d = ex_q + EW'(1);
    end else if (EW'(lz) >= ex_q) begin
      nz_d = 1'b1;
    end else begin
      nm_d = sum_q[XW-1:0] << lz;
      ne_d = ex_q - EW'(lz);
    end
  end

  logic          rup;
  logic [FW:0]   mr;
  logic [EW-1:0] er;
  logic [MAN_W-1:0] fr;

  always_comb begin
    rup = nm_q[2] & (nm_q[1] | nm_q[0] | nm_q[3]);
    mr  = {1'b0, nm_q[XW-1:3]} + {{FW{1'b0}}, rup};
    er  = ne_q;
    fr  = mr[MAN_W-1:0];
    if (mr[FW]) begin
      er = ne_q + EW'(1);
      fr = mr[MAN_W:1];
    end
    res_d = {sgn_q, er[EXP_W-1:0], fr};
    ovf_d = 1'b0;
    nan_d = 1'b0;
    if (sp_nan_q) begin
      res_d = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
      nan_d = 1'b1;
    end else if (sp_inf_q) begin
      res_d = {sp_sgn_q, EMAX, {MAN_W{1'b0}}};
    end else if (nz_q) begin
      res_d = {nzs_q, {(W-1){1'b0}}};
    end else if (er >= {2'b00, EMAX}) begin
      res_d = {sgn_q, EMAX, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end
  end

  // Each stage register loads only while its state is current
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      nan_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          a_q  <= a;
          b_q  <= b;
          op_q <= op;
        end
        S_ALIGN: begin
          ex_q     <= ex_d;
          mb_q     <= mb_d;
          ms_q     <= ms_d;
          sub_q    <= sub_d;
          sgn_q    <= sgn_d;
          zs_q     <= zs_d;
          sp_nan_q <= sp_nan_d;
          sp_inf_q <= sp_inf_d;
          sp_sgn_q <= sp_sgn_d;
        end
        S_ADD: sum_q <= sum_d;
        S_NORM: begin
          nm_q  <= nm_d;
          ne_q  <= ne_d;
          nz_q  <= nz_d;
          nzs_q <= nzs_d;
        end
        S_ROUND: begin
          result_q <= res_d;
          ovf_q    <= ovf_d;
          nan_q    <= nan_d;
        end
        default: ;
      endcase
    end
  end

  assign result   = result_q;
  assign flag_ovf = ovf_q;
  assign flag_nan = nan_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_float_addsub_seq.sv
// Bench for float_addsub_seq: directed vector table, handshake/reset sequences,
// and random operands checked against a real-arithmetic reference model.
module tb_float_addsub_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start_s, start_h, op;
  logic [31:0] a, b;
  logic [31:0] res_s;
  logic        busy_s, done_s, ovf_s, nan_s;
  logic [15:0] res_h;
  logic        busy_h, done_h, ovf_h, nan_h;

  int total = 0;
  int bad   = 0;

  float_addsub_seq u_s (
    .clk(clk), .reset(reset), .start(start_s), .op(op), .a(a), .b(b),
    .result(res_s), .busy(busy_s), .done(done_s), .flag_ovf(ovf_s), .flag_nan(nan_s)
  );

  float_addsub_seq #(.EXP_W(5), .MAN_W(10)) u_h (
    .clk(clk), .reset(reset), .start(start_h), .op(op), .a(a[15:0]), .b(b[15:0]),
    .result(res_h), .busy(busy_h), .done(done_h), .flag_ovf(ovf_h), .flag_nan(nan_h)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] r;
    logic        ovf;
    logic        nan;
  } vec_t;

  vec_t vt[20];

  task automatic check(input string nm, input logic [33:0] act, input logic [33:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  // Returns {flag_nan, flag_ovf, result}
  function automatic logic [33:0] model(input logic [31:0] xa, input logic [31:0] xb,
                                        input logic xop, input int ew, input int mw);
    int bias = (1 << (ew - 1)) - 1;
    int emax = (1 << ew) - 1;
    int ea = int'(xa >> mw) & emax;
    int eb = int'(xb >> mw) & emax;
    int fa = int'(xa) & ((1 << mw) - 1);
    int fb = int'(xb) & ((1 << mw) - 1);
    logic sa = xa[ew+mw];
    logic sb = xb[ew+mw] ^ xop;
    logic [31:0] r = '0;
    real va, vb, s, m, sc, fr;
    int e, q;
    logic neg;
    if ((ea == emax && fa != 0) || (eb == emax && fb != 0) ||
        (ea == emax && eb == emax && sa != sb)) begin
      r = (32'(emax) << mw) | (32'd1 << (mw - 1));
      return {2'b10, r};
    end
    if (ea == emax || eb == emax) begin
      r[ew+mw] = (ea == emax) ? sa : sb;
      r = r | (32'(emax) << mw);
      return {2'b00, r};
    end
    va = (ea == 0) ? 0.0 : (1.0 + $itor(fa) / pow2(mw)) * pow2(ea - bias);
    vb = (eb == 0) ? 0.0 : (1.0 + $itor(fb) / pow2(mw)) * pow2(eb - bias);
    if (sa) va = -va;
    if (sb) vb = -vb;
    s = va + vb;
    if (s == 0.0) begin
      r[ew+mw] = sa & sb;
      return {2'b00, r};
    end
    neg = (s < 0.0);
    m = neg ? -s : s;
    r[ew+mw] = neg;
    if (m < pow2(1 - bias)) return {2'b00, r};
    e = 1 - bias;
    m = m / pow2(e);
    while (m >= 2.0) begin
      m = m / 2.0;
      e++;
    end
    sc = m * pow2(mw);
    q  = $rtoi(sc);
    fr = sc - $itor(q);
    if (fr > 0.5 || (fr == 0.5 && (q % 2) == 1)) q++;
    if (q == (1 << (mw + 1))) begin
      q = q / 2;
      e++;
    end
    if (e + bias >= emax) begin
      r = r | (32'(emax) << mw);
      return {2'b01, r};
    end
    r = r | (32'(e + bias) << mw) | 32'(q - (1 << mw));
    return {2'b00, r};
  endfunction

  task automatic run_op(input logic half, input logic [31:0] ia, input logic [31:0] ib,
                        input logic iop, output logic [33:0] act, output int lat);
    @(negedge clk);
    a = ia;
    b = ib;
    op = iop;
    if (half) start_h = 1'b1;
    else start_s = 1'b1;
    act = '0;
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      start_s = 1'b0;
      start_h = 1'b0;
      if (half ? done_h : done_s) begin
        lat = c;
        act = half ? {nan_h, ovf_h, 16'h0, res_h} : {nan_s, ovf_s, res_s};
        break;
      end
    end
    @(posedge clk);
  endtask

  logic [33:0] act;
  int lat;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{32'h420F0000, 32'h41A40000, 1'b0, 32'h42610000, 1'b0, 1'b0};
    vt[1]  = '{32'h420F0000, 32'h41A40000, 1'b1, 32'h41740000, 1'b0, 1'b0};
    vt[2]  = '{32'h420F0000, 32'h420F0000, 1'b1, 32'h00000000, 1'b0, 1'b0};
    vt[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    vt[4]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 1'b0};
    vt[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0};
    vt[6]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1};
    vt[7]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vt[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0};
    vt[9]  = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b0};
    vt[10] = '{32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0};
    vt[11] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0};
    vt[12] = '{32'h3F800000, 32'hFFC12345, 1'b0, 32'h7FC00000, 1'b0, 1'b1};
    vt[13] = '{32'h00400000, 32'h80000001, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vt[14] = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 1'b0, 1'b0};
    vt[15] = '{32'h3F800001, 32'h2F800000, 1'b1, 32'h3F800001, 1'b0, 1'b0};
    vt[16] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 1'b1, 1'b0};
    vt[17] = '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    vt[18] = '{32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b0};
    vt[19] = '{32'h80C00000, 32'h80800000, 1'b1, 32'h80000000, 1'b0, 1'b0};

    reset = 1'b1;
    start_s = 1'b0;
    start_h = 1'b0;
    op = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_s", {busy_s, done_s, nan_s, ovf_s, res_s}, 36'h0);
    check("reset_h", {busy_h, done_h, nan_h, ovf_h, 16'h0, res_h}, 36'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vt[i]) begin
      run_op(1'b0, vt[i].a, vt[i].b, vt[i].op, act, lat);
      check($sformatf("vec%0d", i), act, {vt[i].nan, vt[i].ovf, vt[i].r});
      check($sformatf("vec%0d_lat", i), 34'(lat), 34'd5);
    end

    run_op(1'b1, 32'h3C00, 32'h3C00, 1'b0, act, lat);
    check("half_1p1", act, {2'b00, 32'h4000});
    check("half_lat", 34'(lat), 34'd5);

    // Starts in ADD and DONE ignored; start in the IDLE after DONE accepted
    begin
      int dcnt = 0, d1 = -1, d2 = -1, bmis = 0;
      logic [33:0] r1 = '0, r2 = '0;
      logic [31:0] hold = '0;
      @(negedge clk);
      a = 32'h420F0000;
      b = 32'h41A40000;
      op = 1'b0;
      start_s = 1'b1;
      for (int c = 1; c <= 16; c++) begin
        @(posedge clk);
        #1;
        start_s = (c == 2 || c == 5 || c == 6);
        if (c == 6) begin
          a = 32'h3F800000;
          b = 32'h3F800000;
        end
        if (busy_s !== ((c >= 1 && c <= 5) || (c >= 7 && c <= 11))) bmis++;
        if (c == 9) hold = res_s;
        if (done_s) begin
          dcnt++;
          if (d1 < 0) begin
            d1 = c;
            r1 = {nan_s, ovf_s, res_s};
          end else begin
            d2 = c;
            r2 = {nan_s, ovf_s, res_s};
          end
        end
      end
      check("hs_done1_cyc", 34'(d1), 34'd5);
      check("hs_res1", r1, {2'b00, 32'h42610000});
      check("hs_done_count", 34'(dcnt), 34'd2);
      check("hs_done2_cyc", 34'(d2), 34'd11);
      check("hs_res2", r2, {2'b00, 32'h40000000});
      check("hs_busy", 34'(bmis), 34'd0);
      check("hs_hold", {2'b00, hold}, {2'b00, 32'h42610000});
    end

    // Reset while in ADD aborts with no done
    begin
      int dcnt = 0;
      logic [35:0] snap = '1;
      @(negedge clk);
      a = 32'h3F800000;
      b = 32'h40000000;
      op = 1'b0;
      start_s = 1'b1;
      for (int c = 1; c <= 12; c++) begin
        @(posedge clk);
        #1;
        start_s = 1'b0;
        if (done_s) dcnt++;
        if (c == 2) reset = 1'b1;
        if (c == 3) begin
          snap = {busy_s, done_s, nan_s, ovf_s, res_s};
          reset = 1'b0;
        end
      end
      check("rst_abort_outs", snap[33:0], 34'h0);
      check("rst_abort_ctl", 34'(snap[35:34]), 34'h0);
      check("rst_abort_nodone", 34'(dcnt), 34'd0);
    end

    // Reset beats start
    @(negedge clk);
    reset = 1'b1;
    start_s = 1'b1;
    @(posedge clk);
    #1;
    check("rst_prio_busy", 34'(busy_s), 34'd0);
    reset = 1'b0;
    start_s = 1'b0;
    @(posedge clk);
    #1;
    check("rst_prio_idle", 34'(busy_s), 34'd0);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra, rb;
      logic rop;
      int k;
      ra = $urandom;
      rb = $urandom;
      k = int'($urandom_range(0, 3));
      if (k == 1) rb[30:23] = ra[30:23] ^ 8'($urandom_range(0, 3));
      if (k == 2) rb = ra ^ 32'($urandom_range(0, 255));
      rop = 1'($urandom_range(0, 1));
      run_op(1'b0, ra, rb, rop, act, lat);
      check($sformatf("rand_s%0d a=%h b=%h op=%0d", i, ra, rb, rop), act, model(ra, rb, rop, 8, 23));
      check($sformatf("rand_s%0d_lat", i), 34'(lat), 34'd5);
    end

    for (int i = 0; i < 100; i++) begin
      logic [31:0] ra, rb;
      logic rop;
      int k;
      ra = $urandom & 32'hFFFF;
      rb = $urandom & 32'hFFFF;
      k = int'($urandom_range(0, 3));
      if (k == 1) rb[14:10] = ra[14:10] ^ 5'($urandom_range(0, 3));
      if (k == 2) rb = ra ^ 32'($urandom_range(0, 63));
      rop = 1'($urandom_range(0, 1));
      run_op(1'b1, ra, rb, rop, act, lat);
      check($sformatf("rand_h%0d a=%h b=%h op=%0d", i, ra, rb, rop), act, model(ra, rb, rop, 5, 10));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
